// File: rtl/fetch_pipelined.sv
// Pipelined fetch unit: shares one synchronous-read memory port between instruction
// fetch and load/store, and buffers PC-tagged instructions in a FWFT FIFO.
module fetch_pipelined #(
  parameter int I_WIDTH    = 13,
  parameter int A_WIDTH    = 10,
  parameter int O_WIDTH    = 5,
  parameter int FIFO_DEPTH = 4,
  localparam int C_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               dequeue_i,
  input  logic               restart_i,
  input  logic [A_WIDTH-1:0] restart_addr_i,
  input  logic               load_store_valid_i,
  input  logic               store_en_i,
  input  logic [A_WIDTH-1:0] load_store_addr_i,
  input  logic [I_WIDTH-1:0] store_data_i,
  output logic [I_WIDTH-1:0] load_data_o,
  output logic               load_data_valid_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  output logic [I_WIDTH-1:0] mem_wdata_o,
  output logic               mem_we_o,
  input  logic [I_WIDTH-1:0] mem_rdata_i,
  output logic [I_WIDTH-1:0] instruction_data_o,
  output logic [A_WIDTH-1:0] instruction_addr_o,
  output logic               instruction_valid_o,
  output logic [C_WIDTH-1:0] fifo_count_o
);

  localparam int P_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int CW1      = C_WIDTH + 1;

  logic [A_WIDTH-1:0] pc_r;
  logic               inflight_valid_r;
  logic               inflight_fetch_r;
  logic [A_WIDTH-1:0] inflight_addr_r;

  logic [I_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
  logic [A_WIDTH-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [P_WIDTH-1:0] wr_ptr_r;
  logic [P_WIDTH-1:0] rd_ptr_r;
  logic [C_WIDTH-1:0] count_r;

  logic               fetch_ret;
  logic               load_ret;
  logic               branch_ret;
  logic               credit_ok;
  logic               fetch_issue;
  logic               enq;
  logic               deq;
  logic               fifo_nonempty;
  logic [A_WIDTH-1:0] branch_target;

  // Exec handshake: instruction_valid_o means the head entry is stable and may be
  // consumed; asserting dequeue_i with valid high pops it at the next edge.
  always_comb begin
    fetch_ret     = inflight_valid_r & inflight_fetch_r;
    load_ret      = inflight_valid_r & ~inflight_fetch_r;
    branch_ret    = fetch_ret & mem_rdata_i[I_WIDTH-1] & ~restart_i;
    // Credits count in-flight fetches and ignore a same-cycle dequeue.
    credit_ok     = ({1'b0, count_r} + CW1'(fetch_ret)) < CW1'(FIFO_DEPTH);
    fetch_issue   = ~load_store_valid_i & ~restart_i & ~branch_ret & credit_ok;
    fifo_nonempty = (count_r != '0);
    enq           = fetch_ret & ~restart_i;
    deq           = dequeue_i & fifo_nonempty & ~restart_i;
    branch_target = inflight_addr_r +
                    {{(A_WIDTH-O_WIDTH){mem_rdata_i[O_WIDTH-1]}}, mem_rdata_i[O_WIDTH-1:0]};
  end

  always_comb begin
    mem_addr_o          = load_store_valid_i ? load_store_addr_i : pc_r;
    mem_wdata_o         = store_data_i;
    mem_we_o            = rst_n_i & load_store_valid_i & store_en_i;
    load_data_valid_o   = load_ret;
    load_data_o         = load_ret ? mem_rdata_i : '0;
    instruction_valid_o = fifo_nonempty;
    instruction_data_o  = fifo_nonempty ? fifo_data_r[rd_ptr_r] : '0;
    instruction_addr_o  = fifo_nonempty ? fifo_addr_r[rd_ptr_r] : '0;
    fifo_count_o        = count_r;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_r <= '0;
    end else if (restart_i) begin
      pc_r <= restart_addr_i;
    end else if (branch_ret) begin
      pc_r <= branch_target;
    end else if (fetch_issue) begin
      pc_r <= pc_r + A_WIDTH'(1);
    end
  end

  // Stores complete in their issue cycle, so only fetches and loads are tracked.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_valid_r <= 1'b0;
      inflight_fetch_r <= 1'b0;
      inflight_addr_r  <= '0;
    end else begin
      inflight_valid_r <= fetch_issue | (load_store_valid_i & ~store_en_i);
      inflight_fetch_r <= fetch_issue;
      inflight_addr_r  <= pc_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (restart_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + P_WIDTH'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + P_WIDTH'(1);
      count_r <= count_r + C_WIDTH'(enq) - C_WIDTH'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= '0;
        fifo_addr_r[i] <= '0;
      end
    end else if (enq) begin
      fifo_data_r[wr_ptr_r] <= mem_rdata_i;
      fifo_addr_r[wr_ptr_r] <= inflight_addr_r;
    end
  end

endmodule

// File: tb/tb_fetch_pipelined.sv
// Directed bench for fetch_pipelined: vector table for sequential fetch/backpressure,
// hand-written sequences for branch, wrap, restart, load/store and async reset.
module tb_fetch_pipelined;

  localparam int IW = 13;
  localparam int AW = 10;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          dequeue_i = 1'b0;
  logic          restart_i = 1'b0;
  logic [AW-1:0] restart_addr_i = '0;
  logic          ls_valid = 1'b0;
  logic          store_en = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [IW-1:0] store_data = '0;
  logic [IW-1:0] load_data_o;
  logic          load_data_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_wdata_o;
  logic          mem_we_o;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] instruction_data_o;
  logic [AW-1:0] instruction_addr_o;
  logic          instruction_valid_o;
  logic [CW-1:0] fifo_count_o;

  fetch_pipelined dut (
    .clk                (clk),
    .rst_n_i            (rst_n),
    .dequeue_i          (dequeue_i),
    .restart_i          (restart_i),
    .restart_addr_i     (restart_addr_i),
    .load_store_valid_i (ls_valid),
    .store_en_i         (store_en),
    .load_store_addr_i  (ls_addr),
    .store_data_i       (store_data),
    .load_data_o        (load_data_o),
    .load_data_valid_o  (load_data_valid_o),
    .mem_addr_o         (mem_addr_o),
    .mem_wdata_o        (mem_wdata_o),
    .mem_we_o           (mem_we_o),
    .mem_rdata_i        (mem_rdata),
    .instruction_data_o (instruction_data_o),
    .instruction_addr_o (instruction_addr_o),
    .instruction_valid_o(instruction_valid_o),
    .fifo_count_o       (fifo_count_o)
  );

  // clock / memory model
  always #5 clk = ~clk;

  logic [IW-1:0] mem [1024];
  logic          mem_init = 1'b0;
  logic          mem_poke = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [IW-1:0] poke_data = '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 13'(i);
    end else if (mem_poke) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_we_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
    end
    mem_rdata <= mem[mem_addr_o];
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic sb_on = 1'b0;
  logic [AW+IW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int a, input int d);
    exp_q.push_back({10'(a), 13'(d)});
  endtask

  task automatic tick();
    logic [AW+IW-1:0] e;
    @(posedge clk);
    #1;
    if (sb_on && instruction_valid_o && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_addr", 32'(instruction_addr_o), 32'(e[AW+IW-1:IW]));
      check("sb_data", 32'(instruction_data_o), 32'(e[IW-1:0]));
    end
  endtask

  task automatic run_sb(input int bound);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < bound) begin
      tick();
      g++;
    end
    check("sb_drain_timeout", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;
  endtask

  // driver tasks
  task automatic reset_begin();
    dequeue_i = 1'b0;
    restart_i = 1'b0;
    ls_valid  = 1'b1;
    store_en  = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("rst_valid", 32'(instruction_valid_o), 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    check("rst_load_valid", 32'(load_data_valid_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    ls_valid = 1'b0;
    store_en = 1'b0;
    mem_init = 1'b1;
    @(posedge clk);
    #1;
    mem_init = 1'b0;
  endtask

  task automatic poke(input int a, input int d);
    poke_addr = 10'(a);
    poke_data = 13'(d);
    mem_poke  = 1'b1;
    @(posedge clk);
    #1;
    mem_poke  = 1'b0;
  endtask

  task automatic reset_end();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int do_reset;
    int deq;
    int e_valid;
    int e_head;
    int e_count;
    int e_maddr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // sequential fetch with continuous dequeue
    vecs[0]  = '{1, 1, 0, 0, 0, 1};
    vecs[1]  = '{0, 1, 1, 0, 1, 2};
    vecs[2]  = '{0, 1, 1, 1, 1, 3};
    vecs[3]  = '{0, 1, 1, 2, 1, 4};
    vecs[4]  = '{0, 1, 1, 3, 1, 5};
    vecs[5]  = '{0, 1, 1, 4, 1, 6};
    // backpressure: fills to 4, stalls at pc 4, one dequeue buys one fetch
    vecs[6]  = '{1, 0, 0, 0, 0, 1};
    vecs[7]  = '{0, 0, 1, 0, 1, 2};
    vecs[8]  = '{0, 0, 1, 0, 2, 3};
    vecs[9]  = '{0, 0, 1, 0, 3, 4};
    vecs[10] = '{0, 0, 1, 0, 4, 4};
    vecs[11] = '{0, 0, 1, 0, 4, 4};
    vecs[12] = '{0, 1, 1, 1, 3, 4};
    vecs[13] = '{0, 0, 1, 1, 3, 5};
    vecs[14] = '{0, 0, 1, 1, 4, 5};
    vecs[15] = '{0, 0, 1, 1, 4, 5};

    #3;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_reset != 0) begin
        reset_begin();
        reset_end();
      end
      dequeue_i = vecs[i].deq[0];
      tick();
      check("vec_valid", 32'(instruction_valid_o), 32'(vecs[i].e_valid));
      check("vec_count", 32'(fifo_count_o), 32'(vecs[i].e_count));
      check("vec_mem_addr", 32'(mem_addr_o), 32'(vecs[i].e_maddr));
      if (vecs[i].e_valid != 0) begin
        check("vec_head_addr", 32'(instruction_addr_o), 32'(vecs[i].e_head));
        check("vec_head_data", 32'(instruction_data_o), 32'(vecs[i].e_head));
      end
    end

    // branch back by 3 at addr 5, then wrap 1023 + 2 -> 1
    reset_begin();
    poke(5, 13'h101D);
    poke(1023, 13'h1002);
    reset_end();
    dequeue_i = 1'b1;
    sb_on = 1'b1;
    for (int a = 0; a < 6; a++) push_exp(a, (a == 5) ? 13'h101D : a);
    for (int a = 2; a < 6; a++) push_exp(a, (a == 5) ? 13'h101D : a);
    push_exp(2, 2);
    run_sb(40);
    restart_i = 1'b1;
    restart_addr_i = 10'd1023;
    tick();
    restart_i = 1'b0;
    check("wrap_restart_count", 32'(fifo_count_o), 32'd0);
    check("wrap_restart_pc", 32'(mem_addr_o), 32'd1023);
    push_exp(1023, 13'h1002);
    for (int a = 1; a < 5; a++) push_exp(a, a);
    sb_on = 1'b1;
    run_sb(30);

    // restart squashes a pending fetch return
    reset_begin();
    reset_end();
    dequeue_i = 1'b0;
    tick();
    tick();
    check("rs_pre_count", 32'(fifo_count_o), 32'd1);
    restart_i = 1'b1;
    restart_addr_i = 10'd100;
    tick();
    check("rs_count", 32'(fifo_count_o), 32'd0);
    check("rs_valid", 32'(instruction_valid_o), 32'd0);
    check("rs_pc", 32'(mem_addr_o), 32'd100);
    restart_i = 1'b0;
    tick();
    check("rs_issue_valid", 32'(instruction_valid_o), 32'd0);
    tick();
    check("rs_first_valid", 32'(instruction_valid_o), 32'd1);
    check("rs_first_addr", 32'(instruction_addr_o), 32'd100);
    check("rs_first_data", 32'(instruction_data_o), 32'd100);
    check("rs_first_count", 32'(fifo_count_o), 32'd1);

    // store then load to addr 50 interleaved with fetch
    reset_begin();
    reset_end();
    dequeue_i = 1'b1;
    sb_on = 1'b1;
    for (int a = 0; a < 10; a++) push_exp(a, a);
    repeat (4) tick();
    ls_valid = 1'b1;
    store_en = 1'b1;
    ls_addr = 10'd50;
    store_data = 13'h1ABC;
    #1;
    check("st_we", 32'(mem_we_o), 32'd1);
    check("st_addr", 32'(mem_addr_o), 32'd50);
    check("st_wdata", 32'(mem_wdata_o), 32'h1ABC);
    tick();
    check("st_no_load_valid", 32'(load_data_valid_o), 32'd0);
    store_en = 1'b0;
    #1;
    check("ld_we", 32'(mem_we_o), 32'd0);
    check("ld_addr", 32'(mem_addr_o), 32'd50);
    tick();
    ls_valid = 1'b0;
    #1;
    check("ld_valid", 32'(load_data_valid_o), 32'd1);
    check("ld_data", 32'(load_data_o), 32'h1ABC);
    check("ld_pc_stalled", 32'(mem_addr_o), 32'd4);
    tick();
    check("ld_valid_once", 32'(load_data_valid_o), 32'd0);
    run_sb(30);

    // async reset mid-cycle with 3 entries and a fetch in flight
    reset_begin();
    reset_end();
    dequeue_i = 1'b0;
    repeat (4) tick();
    check("ar_pre_count", 32'(fifo_count_o), 32'd3);
    #2;
    reset_begin();
    reset_end();
    dequeue_i = 1'b1;
    tick();
    check("ar_first_empty", 32'(instruction_valid_o), 32'd0);
    sb_on = 1'b1;
    for (int a = 0; a < 6; a++) push_exp(a, a);
    run_sb(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
